// File: rtl/memoria_pkg.sv
// Shared definitions for the memoria word store: controller state encoding and
// request direction codes.
package memoria_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/memoria_array.sv
// Word storage for memoria_sync_ctrl: one synchronous write port and one
// registered read port whose output register can be forced to zero.
module memoria_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             rclr,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it can map onto RAM; contents are
    // undefined until a clear sweep or explicit writes fill them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register is ordinary control state, so it does take reset.
    // rclr covers out-of-range reads, which must return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/memoria_sync_ctrl.sv
// Request/ack controller around memoria_array: range check, client/sweep
// write-port arbitration and the bulk-clear sequencer.
module memoria_sync_ctrl
    import memoria_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             rw,
    input  logic [AW-1:0]    add,
    input  logic [WIDTH-1:0] i,
    input  logic             clr_req,
    output logic [WIDTH-1:0] s,
    output logic             ack,
    output logic             err,
    output logic             busy,
    output logic             clr_done
);

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    ptr;
    logic             in_range;
    logic             accept;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic             rclr;

    // Only reachable when DEPTH is not a power of two.
    assign in_range = ({1'b0, add} < DEPTH_W);

    // A clear request in the same cycle pre-empts the client request.
    assign accept = (state == ST_IDLE) && req && !clr_req;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        we    = 1'b0;
        waddr = add;
        wdata = i;
        re    = 1'b0;
        rclr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (rw == RW_WRITE) begin
                        we = in_range;
                    end else begin
                        re   = in_range;
                        rclr = !in_range;
                    end
                end
            end
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = ptr;
                wdata = '0;
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            ack      <= 1'b0;
            err      <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end else if (req) begin
                        ack <= 1'b1;
                        err <= !in_range;
                    end
                end
                ST_CLEAR: begin
                    if (ptr == LAST) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                        ptr      <= '0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    memoria_array #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .rclr  (rclr),
        .raddr (add),
        .rdata (s)
    );

endmodule
